video_timing_gen: RTL and testbench



---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/video_timing_if.sv | 15 +
 rtl/timing_axis_counter.sv | 51 +++++
 rtl/video_timing_gen.sv | 112 +++++++++++
 tb/tb_video_timing_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants for the HDMI picture path and the
// helper that derives total line/frame lengths from a segment set.
package video_timing_pkg;

  typedef struct packed {
    int unsigned sync;
    int unsigned bp;
    int unsigned act;
    int unsigned fp;
  } axis_timing_t;

  // CEA-861 1280x720@60, 74.25 MHz pixel clock
  localparam axis_timing_t H_720P   = '{sync: 40, bp: 220, act: 1280, fp: 110};
  localparam axis_timing_t V_720P   = '{sync: 5,  bp: 20,  act: 720,  fp: 5};
  localparam bit           POL_720P = 1'b1;

  // CEA-861 1920x1080@60, 148.5 MHz pixel clock
  localparam axis_timing_t H_1080P   = '{sync: 44, bp: 148, act: 1920, fp: 88};
  localparam axis_timing_t V_1080P   = '{sync: 5,  bp: 36,  act: 1080, fp: 4};
  localparam bit           POL_1080P = 1'b1;

  function automatic int unsigned axis_total(input int unsigned sync, input int unsigned bp,
                                             input int unsigned act, input int unsigned fp);
    return sync + bp + act + fp;
  endfunction

  function automatic int unsigned h_total(input axis_timing_t t);
    return axis_total(t.sync, t.bp, t.act, t.fp);
  endfunction

  function automatic int unsigned v_total(input axis_timing_t t);
    return axis_total(t.sync, t.bp, t.act, t.fp);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster output bundle from the timing generator to the overlay stage.
interface video_timing_if #(
  parameter int unsigned X_BITS = 12,
  parameter int unsigned Y_BITS = 12
);
  logic              hs_out;
  logic              vs_out;
  logic              de_out;
  logic [X_BITS-1:0] act_x;
  logic [Y_BITS-1:0] act_y;
  logic              frame_start;

  modport master (output hs_out, vs_out, de_out, act_x, act_y, frame_start);
  modport slave  (input  hs_out, vs_out, de_out, act_x, act_y, frame_start);
endinterface

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter with sync/active region decode.
// The total SYNC+BP+ACT+FP must fit in W bits.
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned W    = 12,
  parameter int unsigned SYNC = 40,
  parameter int unsigned BP   = 220,
  parameter int unsigned ACT  = 1280,
  parameter int unsigned FP   = 110
) (
  input  logic         pix_clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         in_sync,
  output logic         in_act
);
  localparam int unsigned  TOTAL     = axis_total(SYNC, BP, ACT, FP);
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_END  = W'(SYNC);
  localparam logic [W-1:0] ACT_START = W'(SYNC + BP);
  localparam logic [W-1:0] ACT_END   = W'(SYNC + BP + ACT);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // wrap is qualified by en so a chained axis sees it only on its own step
  assign wrap = en && (cnt_reg == LAST);

  always_comb begin
    cnt_next = cnt_reg;
    if (en) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + W'(1);
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt     = cnt_reg;
  assign in_sync = (cnt_reg < SYNC_END);
  assign in_act  = (cnt_reg >= ACT_START) && (cnt_reg < ACT_END);

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: registered hs/vs/de, active-area
// coordinates and a frame-start pulse, one cycle behind the counters.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned X_BITS = 12,
  parameter int unsigned Y_BITS = 12,
  parameter int unsigned H_SYNC = H_720P.sync,
  parameter int unsigned H_BP   = H_720P.bp,
  parameter int unsigned H_ACT  = H_720P.act,
  parameter int unsigned H_FP   = H_720P.fp,
  parameter int unsigned V_SYNC = V_720P.sync,
  parameter int unsigned V_BP   = V_720P.bp,
  parameter int unsigned V_ACT  = V_720P.act,
  parameter int unsigned V_FP   = V_720P.fp,
  parameter bit          HS_POL = POL_720P,
  parameter bit          VS_POL = POL_720P
) (
  input logic            pix_clk,
  input logic            rst,
  video_timing_if.master vid
);
  localparam logic [X_BITS-1:0] H_ACT_START = X_BITS'(H_SYNC + H_BP);
  localparam logic [Y_BITS-1:0] V_ACT_START = Y_BITS'(V_SYNC + V_BP);

  logic [X_BITS-1:0] h_cnt;
  logic              h_wrap;
  logic              h_sync;
  logic              h_act;
  logic [Y_BITS-1:0] v_cnt;
  logic              v_wrap;
  logic              v_sync;
  logic              v_act;

  timing_axis_counter #(
    .W(X_BITS), .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)
  ) u_h_axis (
    .pix_clk (pix_clk),
    .rst     (rst),
    .en      (1'b1),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .in_sync (h_sync),
    .in_act  (h_act)
  );

  // Vertical steps once per line, so vs edges land on h_cnt == 0
  timing_axis_counter #(
    .W(Y_BITS), .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)
  ) u_v_axis (
    .pix_clk (pix_clk),
    .rst     (rst),
    .en      (h_wrap),
    .cnt     (v_cnt),
    .wrap    (v_wrap),
    .in_sync (v_sync),
    .in_act  (v_act)
  );

  logic              hs_reg,          hs_next;
  logic              vs_reg,          vs_next;
  logic              de_reg,          de_next;
  logic [X_BITS-1:0] act_x_reg,       act_x_next;
  logic [Y_BITS-1:0] act_y_reg,       act_y_next;
  logic              frame_start_reg, frame_start_next;
  logic              at_origin_reg;

  // The counters sit at (0,0) exactly after reset or after a full-frame wrap,
  // which avoids two wide zero compares for frame_start.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      at_origin_reg <= 1'b1;
    end else begin
      at_origin_reg <= v_wrap;
    end
  end

  always_comb begin
    hs_next          = h_sync ? HS_POL : ~HS_POL;
    vs_next          = v_sync ? VS_POL : ~VS_POL;
    de_next          = h_act & v_act;
    act_x_next       = de_next ? (h_cnt - H_ACT_START) : '0;
    act_y_next       = v_act   ? (v_cnt - V_ACT_START) : '0;
    frame_start_next = at_origin_reg;
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      hs_reg          <= ~HS_POL;
      vs_reg          <= ~VS_POL;
      de_reg          <= 1'b0;
      act_x_reg       <= '0;
      act_y_reg       <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      hs_reg          <= hs_next;
      vs_reg          <= vs_next;
      de_reg          <= de_next;
      act_x_reg       <= act_x_next;
      act_y_reg       <= act_y_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign vid.hs_out      = hs_reg;
  assign vid.vs_out      = vs_reg;
  assign vid.de_out      = de_reg;
  assign vid.act_x       = act_x_reg;
  assign vid.act_y       = act_y_reg;
  assign vid.frame_start = frame_start_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: random reset pulses drive three generators (small timing
// with both polarities, default 720p) checked every cycle against a raster model.
module tb_video_timing_gen;

  typedef struct {
    int hs, hb, ha, hf;
    int vs, vb, va, vf;
    bit hp, vp;
  } tim_t;

  typedef struct {
    bit hs;
    bit vs;
    bit de;
    int x;
    int y;
    bit fs;
  } exp_t;

  localparam tim_t T_SMALL_P = '{hs: 2, hb: 2, ha: 8, hf: 2, vs: 1, vb: 1, va: 4, vf: 1, hp: 1'b1, vp: 1'b1};
  localparam tim_t T_SMALL_N = '{hs: 2, hb: 2, ha: 8, hf: 2, vs: 1, vb: 1, va: 4, vf: 1, hp: 1'b0, vp: 1'b0};
  localparam tim_t T_720P    = '{hs: 40, hb: 220, ha: 1280, hf: 110, vs: 5, vb: 20, va: 720, vf: 5, hp: 1'b1, vp: 1'b1};

  logic pix_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 pix_clk = ~pix_clk;

  video_timing_if #(.X_BITS(12), .Y_BITS(12)) vif_sp ();
  video_timing_if #(.X_BITS(12), .Y_BITS(12)) vif_sn ();
  video_timing_if #(.X_BITS(12), .Y_BITS(12)) vif_hd ();

  video_timing_gen #(
    .X_BITS(12), .Y_BITS(12),
    .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_sp (.pix_clk(pix_clk), .rst(rst), .vid(vif_sp));

  video_timing_gen #(
    .X_BITS(12), .Y_BITS(12),
    .H_SYNC(2), .H_BP(2), .H_ACT(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_sn (.pix_clk(pix_clk), .rst(rst), .vid(vif_sn));

  video_timing_gen u_dut_hd (.pix_clk(pix_clk), .rst(rst), .vid(vif_hd));

  exp_t q_sp[$];
  exp_t q_sn[$];
  exp_t q_hd[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   t_cyc   = 0;
  int   cyc_abs = 0;
  bit   done    = 1'b0;

  // Raster position is pure arithmetic on cycles elapsed since reset release.
  function automatic exp_t model(input tim_t c, input bit r, input int t);
    exp_t e;
    int   h, v, htot, vtot, hx0, vy0;
    bit   hact, vact;
    if (r) begin
      e = '{hs: ~c.hp, vs: ~c.vp, de: 1'b0, x: 0, y: 0, fs: 1'b0};
      return e;
    end
    htot = c.hs + c.hb + c.ha + c.hf;
    vtot = c.vs + c.vb + c.va + c.vf;
    h    = t % htot;
    v    = (t / htot) % vtot;
    hx0  = c.hs + c.hb;
    vy0  = c.vs + c.vb;
    hact = (h >= hx0) && (h < hx0 + c.ha);
    vact = (v >= vy0) && (v < vy0 + c.va);
    e.hs = (h < c.hs) ? c.hp : ~c.hp;
    e.vs = (v < c.vs) ? c.vp : ~c.vp;
    e.de = hact && vact;
    e.x  = e.de ? h - hx0 : 0;
    e.y  = vact ? v - vy0 : 0;
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  task automatic step(input bit r);
    rst = r;
    q_sp.push_back(model(T_SMALL_P, r, t_cyc));
    q_sn.push_back(model(T_SMALL_N, r, t_cyc));
    q_hd.push_back(model(T_720P,    r, t_cyc));
    t_cyc = r ? 0 : t_cyc + 1;
    @(negedge pix_clk);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_abs, got, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e, input logic hs, input logic vs,
                         input logic de, input logic [11:0] x, input logic [11:0] y,
                         input logic fs);
    chk({tag, ".hs_out"},      int'(hs), int'(e.hs));
    chk({tag, ".vs_out"},      int'(vs), int'(e.vs));
    chk({tag, ".de_out"},      int'(de), int'(e.de));
    chk({tag, ".act_x"},       int'(x),  e.x);
    chk({tag, ".act_y"},       int'(y),  e.y);
    chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
  endtask

  // Monitor: the generator presents a new output every clock
  initial begin
    forever begin
      @(posedge pix_clk);
      #1;
      if (done) break;
      cyc_abs++;
      if (q_sp.size() == 0 || q_sn.size() == 0 || q_hd.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard_underflow cycle %0d: got empty queue expected entry", cyc_abs);
      end else begin
        cmp_all("small_pos", q_sp.pop_front(), vif_sp.hs_out, vif_sp.vs_out, vif_sp.de_out,
                vif_sp.act_x, vif_sp.act_y, vif_sp.frame_start);
        cmp_all("small_neg", q_sn.pop_front(), vif_sn.hs_out, vif_sn.vs_out, vif_sn.de_out,
                vif_sn.act_x, vif_sn.act_y, vif_sn.frame_start);
        cmp_all("hd720",     q_hd.pop_front(), vif_hd.hs_out, vif_hd.vs_out, vif_hd.de_out,
                vif_hd.act_x, vif_hd.act_y, vif_hd.frame_start);
      end
    end
  end

  // Stimulus
  initial begin
    int run_len;
    int rst_len;
    for (int i = 0; i < 3; i++) step(1'b1);
    $display("txn initial reset: 3 cycles");

    // Small raster reaches act_x=5, act_y=2 on the output at t=65
    while (t_cyc < 66) step(1'b0);
    $display("txn reset mid active line (small act_x=5 act_y=2): 3 cycles");
    for (int i = 0; i < 3; i++) step(1'b1);

    // Long run covers many small frames and the full 720p vsync (8250 cycles)
    for (int i = 0; i < 9000; i++) step(1'b0);
    $display("txn free run: 9000 cycles");

    for (int k = 0; k < 25; k++) begin
      run_len = int'($urandom_range(0, 400));
      rst_len = int'($urandom_range(1, 4));
      for (int i = 0; i < run_len; i++) step(1'b0);
      for (int i = 0; i < rst_len; i++) step(1'b1);
      $display("txn random episode %0d: run %0d cycles then reset %0d cycles", k, run_len, rst_len);
    end

    for (int i = 0; i < 200; i++) step(1'b0);
    $display("txn final run: 200 cycles");

    done = 1'b1;
    #20;
    chk("scoreboard_drained", q_sp.size() + q_sn.size() + q_hd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
